// File: rtl/pp_pipeline_accel_pix_unpack_pkg.sv
// Shared constants and FSM state type for the pixel unpacker stage of pp_pipeline_accel.
package pp_pipeline_accel_pix_unpack_pkg;

    localparam int PP_STREAM_W = 64;
    localparam int PP_PIX_W    = 24;
    localparam int PP_DIM_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Bit count spans 0..IN_W+PIX_W-1, the deepest the accumulator can get.
    function automatic int cnt_width(input int in_w, input int pix_w);
        return $clog2(in_w + pix_w);
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_pix_unpack_if.sv
// Stream FIFO handshakes around the unpacker: upstream read side and downstream write side.
interface pp_pipeline_accel_pix_unpack_if
    import pp_pipeline_accel_pix_unpack_pkg::*;
#(
    parameter int IN_W  = PP_STREAM_W,
    parameter int PIX_W = PP_PIX_W
);

    logic             in_empty_n;
    logic [IN_W-1:0]  in_dout;
    logic             in_read;
    logic             out_full_n;
    logic [PIX_W-1:0] out_din;
    logic             out_write;

    modport master (
        input  in_empty_n,
        input  in_dout,
        output in_read,
        input  out_full_n,
        output out_din,
        output out_write
    );

    modport slave (
        output in_empty_n,
        output in_dout,
        input  in_read,
        output out_full_n,
        input  out_din,
        input  out_write
    );

endinterface

// File: rtl/pp_pipeline_accel_pix_unpack_acc.sv
// Bit accumulator: drops PIX_W bits on emit and appends a full input word above the survivors on load.
module pp_pipeline_accel_pix_unpack_acc
    import pp_pipeline_accel_pix_unpack_pkg::*;
#(
    parameter int IN_W  = PP_STREAM_W,
    parameter int PIX_W = PP_PIX_W,
    parameter int CNT_W = cnt_width(IN_W, PIX_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             emit,
    input  logic             load,
    input  logic [IN_W-1:0]  din,
    output logic [PIX_W-1:0] pix,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] cnt_a
);

    localparam int ACC_W = IN_W + PIX_W - 1;
    localparam logic [CNT_W-1:0] PIX_CNT = CNT_W'(PIX_W);
    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_shift;
    logic [ACC_W-1:0] acc_fill;

    // Bits above acc_cnt are always zero, so the new word can simply be OR-ed in.
    always_comb begin
        cnt_a     = acc_cnt - (emit ? PIX_CNT : '0);
        acc_shift = emit ? (acc >> PIX_W) : acc;
        acc_fill  = load ? (ACC_W'(din) << cnt_a) : '0;
    end

    assign pix = acc[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            acc     <= acc_shift | acc_fill;
            acc_cnt <= cnt_a + (load ? IN_CNT : '0);
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_pix_unpack.sv
// Pops packed stream words and pushes LSB-first PIX_W pixels for a rows x cols frame,
// starting every row on a fresh input word.
module pp_pipeline_accel_pix_unpack
    import pp_pipeline_accel_pix_unpack_pkg::*;
#(
    parameter int IN_W  = PP_STREAM_W,
    parameter int PIX_W = PP_PIX_W,
    parameter int DIM_W = PP_DIM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] cols,
    input  logic [DIM_W-1:0] rows,
    output logic             idle,
    output logic             done,
    pp_pipeline_accel_pix_unpack_if.master bus
);

    localparam int CNT_W = cnt_width(IN_W, PIX_W);
    localparam logic [CNT_W-1:0] PIX_CNT = CNT_W'(PIX_W);

    state_t           state;
    logic [DIM_W-1:0] cols_r;
    logic [DIM_W-1:0] rows_r;
    logic [DIM_W-1:0] col_cnt;
    logic [DIM_W-1:0] row_cnt;
    logic [DIM_W-1:0] px_left;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] cnt_a;
    logic             run;
    logic             emit;
    logic             read;
    logic             last_col;
    logic             last_row;
    logic             row_end;
    logic             clear;

    // A word is only fetched when the next pixel cannot be formed and the row still needs pixels,
    // which keeps reads from spilling past the row's last word.
    always_comb begin
        run      = (state == ST_RUN) && !reset;
        emit     = run && (acc_cnt >= PIX_CNT) && bus.out_full_n;
        px_left  = cols_r - col_cnt - DIM_W'(emit);
        read     = run && bus.in_empty_n && (cnt_a < PIX_CNT) && (px_left != '0);
        last_col = (col_cnt == cols_r - DIM_W'(1));
        last_row = (row_cnt == rows_r - DIM_W'(1));
        row_end  = emit && last_col;
        clear    = row_end || ((state == ST_IDLE) && start);
    end

    assign bus.in_read   = read;
    assign bus.out_write = emit;

    pp_pipeline_accel_pix_unpack_acc #(
        .IN_W  (IN_W),
        .PIX_W (PIX_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .emit    (emit),
        .load    (read),
        .din     (bus.in_dout),
        .pix     (bus.out_din),
        .acc_cnt (acc_cnt),
        .cnt_a   (cnt_a)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idle    <= 1'b1;
            done    <= 1'b0;
            cols_r  <= '0;
            rows_r  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cols_r  <= cols;
                        rows_r  <= rows;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        idle    <= 1'b0;
                        if (cols == '0 || rows == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (emit) begin
                        if (last_col) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + DIM_W'(1);
                            if (last_row) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + DIM_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idle  <= 1'b1;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    idle  <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_pix_unpack.sv
// Bench for the pixel unpacker: frame-level pixel model, upstream word store and downstream checker.
module tb_pp_pipeline_accel_pix_unpack;

    localparam int IW = 64;
    localparam int PW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] cols;
    logic [DW-1:0] rows;
    logic          idle;
    logic          done;

    always #5 clk = ~clk;

    pp_pipeline_accel_pix_unpack_if #(.IN_W(IW), .PIX_W(PW)) bus ();

    pp_pipeline_accel_pix_unpack #(
        .IN_W  (IW),
        .PIX_W (PW),
        .DIM_W (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .cols  (cols),
        .rows  (rows),
        .idle  (idle),
        .done  (done),
        .bus   (bus.master)
    );

    int          checks = 0;
    int          errors = 0;
    logic [IW-1:0] word_mem [64];
    int          n_words, rd_idx;
    logic [PW-1:0] exp_pix [256];
    logic [PW-1:0] got [256];
    int          exp_n, exp_reads;
    int          got_n, reads_n, row_reads, row_emits, cols_cur;
    int          done_cnt, cyc, start_cyc, done_cyc, first_wr, last_wr;
    int          gap_left, bp_phase, bp_mode, gap_mode;
    logic        start_drv, reset_drv, prev_blocked;
    logic [PW-1:0] prev_din;

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Expected pixels: each row is the LSB-first concatenation of its own words, sliced into pixels.
    task automatic buildExpect(input int c, input int r);
        logic [IW*8-1:0] rowbits;
        int wpr;
        wpr = (c * PW + IW - 1) / IW;
        exp_n = 0;
        exp_reads = r * wpr;
        for (int rr = 0; rr < r; rr++) begin
            rowbits = '0;
            for (int j = 0; j < wpr; j++) rowbits[j*IW +: IW] = word_mem[rr*wpr + j];
            for (int k = 0; k < c; k++) begin
                if (exp_n < 256) exp_pix[exp_n] = rowbits[k*PW +: PW];
                exp_n++;
            end
        end
    endtask

    task automatic loadBytes(input int nbytes);
        int nw;
        nw = (nbytes + 7) / 8;
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < 8; b++) word_mem[w][b*8 +: 8] = 8'(w * 8 + b);
        word_mem[nw] = {$urandom, $urandom};
        n_words = nw + 1;
    endtask

    task automatic loadRandom(input int nw);
        for (int w = 0; w <= nw; w++) word_mem[w] = {$urandom, $urandom};
        n_words = nw + 1;
    endtask

    task automatic checkOutput();
        logic w, r;
        int avail;
        cyc++;
        if (reset) begin
            checkEq("reset_in_read", bus.in_read, 0);
            checkEq("reset_out_write", bus.out_write, 0);
            prev_blocked = 1'b0;
            return;
        end
        w = bus.out_write;
        r = bus.in_read;
        if (w) begin
            checkEq("write_while_full", bus.out_full_n, 1);
            if (got_n >= exp_n) checkEq("extra_pixel", got_n, exp_n);
            else checkEq("pixel", bus.out_din, exp_pix[got_n]);
            if (got_n < 256) got[got_n] = bus.out_din;
            got_n++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (r) begin
            avail = row_reads * IW - (row_emits + int'(w)) * PW;
            checkEq("read_ahead_ok",
                    (bus.in_empty_n && avail < PW && (row_emits + int'(w)) < cols_cur), 1);
            rd_idx++;
            reads_n++;
            row_reads++;
            gap_left = (gap_mode == 1) ? 5 : 0;
        end
        row_emits += int'(w);
        if (cols_cur > 0 && row_emits == cols_cur) begin
            row_emits = 0;
            row_reads = 0;
        end
        if (prev_blocked) checkEq("din_stable", bus.out_din, prev_din);
        prev_blocked = !bus.out_full_n && !r && !w && !start;
        prev_din = bus.out_din;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start && idle) start_cyc = cyc;
    endtask

    task automatic tick();
        @(negedge clk);
        start = start_drv;
        reset = reset_drv;
        case (bp_mode)
            1:       bus.out_full_n = (bp_phase % 3 == 0);
            2:       bus.out_full_n = ($urandom_range(0, 1) == 1);
            default: bus.out_full_n = 1'b1;
        endcase
        bp_phase++;
        if (gap_left > 0) begin
            bus.in_empty_n = 1'b0;
            gap_left--;
        end else if (gap_mode == 2) begin
            bus.in_empty_n = (rd_idx < n_words) && ($urandom_range(0, 3) != 0);
        end else begin
            bus.in_empty_n = (rd_idx < n_words);
        end
        bus.in_dout = (rd_idx < n_words) ? word_mem[rd_idx] : {$urandom, $urandom};
        #2 checkOutput();
    endtask

    // Runs one frame; abort_at > 0 asserts reset once that many pixels have been written.
    task automatic applyStimulus(input int c, input int r, input int abort_at);
        bit finished;
        cols = DW'(c);
        rows = DW'(r);
        cols_cur = c;
        rd_idx = 0; got_n = 0; reads_n = 0; row_reads = 0; row_emits = 0;
        done_cnt = 0; first_wr = -1; last_wr = -1; gap_left = 0; bp_phase = 0;
        done_cyc = -1; start_cyc = -1;
        buildExpect(c, r);
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            tick();
            if (done_cnt > 0) finished = 1'b1;
            if (abort_at > 0 && got_n >= abort_at) finished = 1'b1;
        end
        if (abort_at > 0) begin
            checkEq("abort_reached", got_n, abort_at);
            reset_drv = 1'b1;
            tick();
            tick();
            checkEq("abort_idle", idle, 1);
            checkEq("abort_done", done, 0);
            reset_drv = 1'b0;
            tick();
            return;
        end
        if (done_cnt == 0) checkEq("frame_timeout", 0, 1);
        tick();
        tick();
        checkEq("pixel_count", got_n, exp_n);
        checkEq("read_count", reads_n, exp_reads);
        checkEq("done_pulses", done_cnt, 1);
        checkEq("idle_after", idle, 1);
        if (exp_n > 0) checkEq("done_after_last", done_cyc - last_wr, 1);
        else checkEq("done_after_start", done_cyc - start_cyc, 1);
    endtask

    initial begin
        cyc = 0; prev_blocked = 1'b0; prev_din = '0;
        bp_mode = 0; gap_mode = 0; n_words = 0; rd_idx = 0; gap_left = 0; bp_phase = 0;
        cols_cur = 0; exp_n = 0; got_n = 0;
        start = 1'b0; reset = 1'b1; cols = '0; rows = '0;
        bus.in_empty_n = 1'b0; bus.in_dout = '0; bus.out_full_n = 1'b1;
        start_drv = 1'b0; reset_drv = 1'b1;
        tick(); tick(); tick();
        checkEq("reset_idle", idle, 1);
        checkEq("reset_done_low", done, 0);
        checkEq("reset_out_din", bus.out_din, 0);
        reset_drv = 1'b0;
        tick();

        $display("[TB] layout");
        loadBytes(24);
        applyStimulus(8, 1, 0);
        checkEq("model_pix0", exp_pix[0], 24'h020100);
        checkEq("model_pix7", exp_pix[7], 24'h171615);
        checkEq("layout_pix1", got[1], 24'h050403);
        checkEq("layout_pix7", got[7], 24'h171615);
        checkEq("layout_burst", last_wr - first_wr, 7);
        checkEq("layout_reads", reads_n, 3);

        $display("[TB] row padding");
        loadBytes(32);
        applyStimulus(3, 2, 0);
        checkEq("model_row1_pix0", exp_pix[3], 24'h121110);
        checkEq("pad_row0_last", got[2], 24'h080706);
        checkEq("pad_row1_first", got[3], 24'h121110);
        checkEq("pad_row1_last", got[5], 24'h181716);
        checkEq("pad_reads", reads_n, 4);

        $display("[TB] backpressure");
        bp_mode = 1;
        loadBytes(24);
        applyStimulus(8, 1, 0);
        checkEq("bp_pix7", got[7], 24'h171615);
        bp_mode = 0;

        $display("[TB] underflow");
        gap_mode = 1;
        loadBytes(24);
        applyStimulus(8, 1, 0);
        checkEq("uf_pix4", got[4], 24'h0e0d0c);
        gap_mode = 0;

        $display("[TB] degenerate");
        loadBytes(24);
        applyStimulus(0, 5, 0);
        checkEq("degen_reads", reads_n, 0);

        $display("[TB] reset mid-frame");
        loadBytes(24);
        applyStimulus(8, 1, 4);
        loadBytes(24);
        applyStimulus(8, 1, 0);
        checkEq("rerun_pix0", got[0], 24'h020100);
        checkEq("rerun_burst", last_wr - first_wr, 7);

        $display("[TB] random frames");
        for (int t = 0; t < 10; t++) begin
            int c, r;
            c = $urandom_range(1, 20);
            r = $urandom_range(1, 3);
            bp_mode = $urandom_range(0, 2);
            gap_mode = $urandom_range(0, 2);
            loadRandom(r * ((c * PW + IW - 1) / IW));
            applyStimulus(c, r, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
